// File: rtl/change_disp_pkg.sv
// ---------------------------------------------------------------------------
// change_disp_pkg
//   Shared constants and helpers for the change display multiplexer:
//   active-low seven-segment patterns (bit0 = a ... bit6 = g), the BCD digit
//   lookup, the conversion FSM state type and a power-of-ten helper used to
//   size the overflow threshold.
// ---------------------------------------------------------------------------
package change_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;  // only segment g lit

  // Index = decimal digit, value = active-low pattern g..a.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  // Codes 10..15 are not decimal digits and display as blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    if (bcd <= 4'd9) return SEG_TABLE[bcd];
    return SEG_BLANK;
  endfunction

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage : change_disp_pkg

// File: rtl/change_display_mux_decode.sv
// ---------------------------------------------------------------------------
// seg7_digit_decode
//   Combinational single-digit seven-segment decoder.
//   Ports:
//     bcd   in  4  digit code
//     blank in  1  force all segments off (highest priority)
//     dash  in  1  show a dash (overflow indication)
//     seg   out 7  active-low segments, bit0 = a ... bit6 = g
// ---------------------------------------------------------------------------
module seg7_digit_decode
  import change_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    if (blank)     seg = SEG_BLANK;
    else if (dash) seg = SEG_DASH;
    else           seg = bcd_to_seg(bcd);
  end

endmodule : seg7_digit_decode

// File: rtl/change_display_mux.sv
// ---------------------------------------------------------------------------
// change_display_mux
//   Captures a binary change amount, converts it to BCD with a sequential
//   shift-add-3 engine (one bit per clock) and drives a time-multiplexed
//   seven-segment display with leading-zero blanking and an overflow dash.
//   The display shows the last committed result; a new result is committed
//   atomically on the final shift so no partial digits ever appear.
//   Ports:
//     clk     in  1           rising-edge clock
//     reset_n in  1           asynchronous active-low reset
//     load    in  1           one-cycle capture strobe (ignored while busy)
//     value   in  VAL_W       binary amount
//     busy    out 1           conversion in progress
//     seg     out 7           active-low segments, bit0 = a ... bit6 = g
//     an      out NUM_DIGITS  active-low digit enables, bit0 = LS digit
// ---------------------------------------------------------------------------
module change_display_mux
  import change_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 3,
  parameter int VAL_W       = 8,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [VAL_W-1:0]      value,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int          BCD_W   = 4 * NUM_DIGITS;
  localparam int          CNT_W   = $clog2(VAL_W + 1);
  localparam int          PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int          SCAN_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [31:0] MAX_VAL = 32'(pow10(NUM_DIGITS) - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [VAL_W-1:0]        r_shift;
  logic [BCD_W-1:0]        r_bcd_work;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic                    r_ovf_work;
  logic [BCD_W-1:0]        r_bcd_commit;
  logic                    r_ovf_commit;
  logic [PRESC_W-1:0]      r_presc;
  logic [SCAN_W-1:0]       r_scan;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;

  logic [BCD_W-1:0]        w_adj;
  logic [BCD_W-1:0]        w_shifted;
  logic                    w_last;
  logic [NUM_DIGITS-1:0]   w_lz_blank;
  logic [3:0]              w_cur_bcd;
  logic                    w_blank_cur;
  logic [6:0]              w_seg;

  // ---------------- conversion FSM ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  assign w_last = (r_bit_cnt == CNT_W'(1));

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned (which would infer a latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (load)   w_state_next = CONVERT;
      CONVERT: if (w_last) w_state_next = IDLE;
      default:             w_state_next = IDLE;
    endcase
  end

  assign busy = (r_state == CONVERT);

  // ---------------- shift-add-3 datapath ----------------
  always_comb begin
    w_adj = r_bcd_work;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd_work[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd_work[4*i +: 4] + 4'd3;
    end
  end

  // Carry out of the top digit falls off; overflow covers those values.
  assign w_shifted = {w_adj[BCD_W-2:0], r_shift[VAL_W-1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_bcd_work   <= '0;
      r_bit_cnt    <= '0;
      r_ovf_work   <= 1'b0;
      r_bcd_commit <= '0;
      r_ovf_commit <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_shift    <= value;
            r_bcd_work <= '0;
            r_bit_cnt  <= CNT_W'(VAL_W);
            r_ovf_work <= (32'(value) > MAX_VAL);
          end
        end
        CONVERT: begin
          r_shift    <= r_shift << 1;
          r_bcd_work <= w_shifted;
          r_bit_cnt  <= r_bit_cnt - CNT_W'(1);
          // Commit on the final shift so the display switches in one step.
          if (w_last) begin
            r_bcd_commit <= w_shifted;
            r_ovf_commit <= r_ovf_work;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- digit scan ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_scan  <= '0;
    end else if (r_presc == PRESC_W'(REFRESH_DIV - 1)) begin
      r_presc <= '0;
      r_scan  <= (r_scan == SCAN_W'(NUM_DIGITS - 1)) ? '0 : r_scan + SCAN_W'(1);
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Digit i (i > 0) is a leading zero when it and every digit above it are 0.
  always_comb begin
    logic v_zero;
    v_zero     = 1'b1;
    w_lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      v_zero        = v_zero && (r_bcd_commit[4*i +: 4] == 4'd0);
      w_lz_blank[i] = v_zero;
    end
  end

  assign w_cur_bcd   = r_bcd_commit[4*r_scan +: 4];
  assign w_blank_cur = (BLANK_LZ != 0) && !r_ovf_commit && w_lz_blank[r_scan];

  seg7_digit_decode u_decode (
    .bcd   (w_cur_bcd),
    .blank (w_blank_cur),
    .dash  (r_ovf_commit),
    .seg   (w_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_blank_cur ? '1 : ~(NUM_DIGITS'(1) << r_scan);
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule : change_display_mux

// File: tb/tb_change_display_mux.sv
// ---------------------------------------------------------------------------
// tb_change_display_mux
//   Four instances cover the parameter variants (3/4 digits, 8/10-bit input,
//   blanking on/off). Stimulus pushes the expected display frame into a
//   scoreboard queue; an independent monitor waits for the conversion to end,
//   watches one full scan and compares every digit against the frame.
// ---------------------------------------------------------------------------
module tb_change_display_mux;

  localparam logic [6:0] S_BLK  = 7'b1111111;
  localparam logic [6:0] S_DASH = 7'b0111111;
  localparam logic [6:0] SEG_REF [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam int CAP_CYC = 16;  // two full scans of a 4-digit, div-2 display
  localparam int BLK = -1;
  localparam int DSH = 10;

  typedef struct {
    int              dut;
    bit              wait_busy;
    logic [3:0]      exp_en;
    logic [3:0][6:0] exp_seg;
    string           name;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] load;
  logic [9:0] val10;

  logic       busy_a, busy_b, busy_c, busy_d;
  logic [6:0] seg_a, seg_b, seg_c, seg_d;
  logic [2:0] an_a, an_d;
  logic [3:0] an_b, an_c;

  logic [6:0] seg_w  [4];
  logic [3:0] an_w   [4];
  logic       busy_w [4];

  frame_t sb_q[$];
  int     push_cnt = 0;
  int     done_cnt = 0;
  int     checks   = 0;
  int     errors   = 0;

  always #5 clk = ~clk;

  change_display_mux #(.NUM_DIGITS(3), .VAL_W(8), .REFRESH_DIV(2), .BLANK_LZ(1)) u_a (
    .clk(clk), .reset_n(reset_n), .load(load[0]), .value(val10[7:0]),
    .busy(busy_a), .seg(seg_a), .an(an_a));
  change_display_mux #(.NUM_DIGITS(4), .VAL_W(8), .REFRESH_DIV(2), .BLANK_LZ(1)) u_b (
    .clk(clk), .reset_n(reset_n), .load(load[1]), .value(val10[7:0]),
    .busy(busy_b), .seg(seg_b), .an(an_b));
  change_display_mux #(.NUM_DIGITS(4), .VAL_W(8), .REFRESH_DIV(2), .BLANK_LZ(0)) u_c (
    .clk(clk), .reset_n(reset_n), .load(load[2]), .value(val10[7:0]),
    .busy(busy_c), .seg(seg_c), .an(an_c));
  change_display_mux #(.NUM_DIGITS(3), .VAL_W(10), .REFRESH_DIV(2), .BLANK_LZ(1)) u_d (
    .clk(clk), .reset_n(reset_n), .load(load[3]), .value(val10),
    .busy(busy_d), .seg(seg_d), .an(an_d));

  // 3-digit instances are padded with a permanently disabled digit 3.
  assign seg_w[0] = seg_a;  assign an_w[0] = {1'b1, an_a};  assign busy_w[0] = busy_a;
  assign seg_w[1] = seg_b;  assign an_w[1] = an_b;          assign busy_w[1] = busy_b;
  assign seg_w[2] = seg_c;  assign an_w[2] = an_c;          assign busy_w[2] = busy_c;
  assign seg_w[3] = seg_d;  assign an_w[3] = {1'b1, an_d};  assign busy_w[3] = busy_d;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  // Digits given MS first; BLK = blanked, DSH = dash, otherwise 0..9.
  function automatic frame_t make_frame(input int dut, input bit wb,
                                        input int d3, input int d2, input int d1,
                                        input int d0, input string name);
    frame_t f;
    int     dg [4];
    dg = '{d0, d1, d2, d3};
    f.dut = dut;
    f.wait_busy = wb;
    f.name = name;
    for (int i = 0; i < 4; i++) begin
      if (dg[i] == BLK) begin
        f.exp_en[i] = 1'b0; f.exp_seg[i] = S_BLK;
      end else if (dg[i] == DSH) begin
        f.exp_en[i] = 1'b1; f.exp_seg[i] = S_DASH;
      end else begin
        f.exp_en[i] = 1'b1; f.exp_seg[i] = SEG_REF[dg[i]];
      end
    end
    return f;
  endfunction

  task automatic push(input frame_t f);
    sb_q.push_back(f);
    push_cnt++;
  endtask

  task automatic do_load(input int dut, input int v);
    @(negedge clk);
    val10     = 10'(v);
    load[dut] = 1'b1;
    @(negedge clk);
    load[dut] = 1'b0;
  endtask

  // Called right after do_load: counts negedges with busy high.
  task automatic count_busy(input int dut, input int exp_len, input string name);
    int n;
    n = 0;
    while (busy_w[dut] && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, " busy_len"}, n, exp_len);
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 400 && done_cnt != push_cnt; c++) @(negedge clk);
    check({name, " drained"}, done_cnt, push_cnt);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    frame_t          f;
    logic            prev;
    bit              fell;
    bit              bad;
    int              idx;
    int              nz;
    logic [3:0]      seen;
    logic [3:0][6:0] got;
    logic [3:0]      a;
    logic [6:0]      s;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        f = sb_q.pop_front();
        if (f.wait_busy) begin
          prev = busy_w[f.dut];
          fell = 1'b0;
          for (int c = 0; c < 200 && !fell; c++) begin
            @(negedge clk);
            if (prev && !busy_w[f.dut]) fell = 1'b1;
            prev = busy_w[f.dut];
          end
          check({f.name, " busy_fall"}, 32'(fell), 32'd1);
        end
        seen = '0;
        bad  = 1'b0;
        for (int i = 0; i < 4; i++) got[i] = S_BLK;
        for (int c = 0; c < CAP_CYC; c++) begin
          @(negedge clk);
          a = an_w[f.dut];
          s = seg_w[f.dut];
          if (a == 4'hF) begin
            if (s != S_BLK) bad = 1'b1;
          end else begin
            idx = 0;
            nz  = 0;
            for (int i = 0; i < 4; i++) if (!a[i]) begin idx = i; nz++; end
            if (nz != 1) bad = 1'b1;
            else begin
              seen[idx] = 1'b1;
              got[idx]  = s;
            end
          end
        end
        for (int i = 0; i < 4; i++)
          check($sformatf("%s digit%0d en,seg", f.name, i),
                {seen[i], got[i]}, {f.exp_en[i], f.exp_seg[i]});
        check({f.name, " one_cold_an"}, 32'(bad), 32'd0);
        done_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    reset_n = 1'b0;
    load    = '0;
    val10   = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset dut%0d seg", d),  seg_w[d],  S_BLK);
      check($sformatf("reset dut%0d an", d),   an_w[d],   4'hF);
      check($sformatf("reset dut%0d busy", d), busy_w[d], 1'b0);
    end

    @(negedge clk);
    reset_n = 1'b1;
    push(make_frame(0, 1'b0, BLK, BLK, BLK, 0, "after_reset"));
    wait_done("after_reset");

    push(make_frame(0, 1'b1, BLK, BLK, BLK, 5, "val5"));
    do_load(0, 5);
    count_busy(0, 8, "val5");
    wait_done("val5");

    push(make_frame(1, 1'b1, BLK, 2, 0, 5, "val205_lz"));
    do_load(1, 205);
    count_busy(1, 8, "val205_lz");
    wait_done("val205_lz");

    push(make_frame(2, 1'b1, 0, 2, 0, 5, "val205_nolz"));
    do_load(2, 205);
    wait_done("val205_nolz");

    push(make_frame(3, 1'b1, BLK, DSH, DSH, DSH, "val1000_ovf"));
    do_load(3, 1000);
    count_busy(3, 10, "val1000_ovf");
    wait_done("val1000_ovf");

    push(make_frame(3, 1'b1, BLK, 9, 9, 9, "val999"));
    do_load(3, 999);
    wait_done("val999");

    // Second strobe lands two cycles into the conversion and must be ignored.
    push(make_frame(0, 1'b1, BLK, BLK, 3, 7, "val37_ignore99"));
    @(negedge clk); val10 = 10'd37; load[0] = 1'b1;
    @(negedge clk); load[0] = 1'b0;
    @(negedge clk); val10 = 10'd99; load[0] = 1'b1;
    @(negedge clk); load[0] = 1'b0;
    wait_done("val37_ignore99");
    check("no_restart busy", busy_a, 1'b0);

    // Abort mid-conversion with an asynchronous reset.
    do_load(0, 200);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset busy", busy_a, 1'b0);
    check("midreset seg", seg_a, S_BLK);
    check("midreset an", an_a, 3'b111);
    @(negedge clk);
    reset_n = 1'b1;

    push(make_frame(0, 1'b1, BLK, BLK, 4, 2, "val42_after_abort"));
    do_load(0, 42);
    count_busy(0, 8, "val42_after_abort");
    wait_done("val42_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_change_display_mux
